pdm_deserializer: RTL and testbench

//  Receive side of the audio bit-stream path; the counterpart of the PWM output serializer.
//  - Generates the microphone bit clock and samples the 1-bit PDM input once per bit period.
//  - Assembles WORD_LENGTH consecutive bits MSB-first into a parallel word.
//  - Presents each word with a valid/ready handshake to the downstream filter/FIFO.

---
 rtl/audio_pkg.sv | 17 +
 rtl/pdm_clock_gen.sv | 36 +++
 rtl/pdm_deserializer.sv | 189 ++++++++++++++++++
 tb/tb_pdm_deserializer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and helpers for the PDM microphone receive path.
// Holds the FSM encoding, the clock divider helper and the synchronizer depth.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } pdm_state_t;

    localparam int PDM_SYNC_STAGES = 2;

    function automatic int pdm_div(input int sys, input int samp);
        return (samp > 0) ? (sys / samp) : 0;
    endfunction

endpackage

// File: rtl/pdm_clock_gen.sv
// Microphone bit-clock generator: divides clock_i by DIV while running.
// Emits a one-cycle sample strobe on the last count of each bit period.
module pdm_clock_gen
    import audio_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic run_i,
    output logic pdm_clk_o,
    output logic strobe_o
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_pdm_clk;
    logic          w_last;

    assign w_last    = (r_cnt == CW'(DIV - 1));
    assign strobe_o  = run_i && w_last;
    assign pdm_clk_o = r_pdm_clk;

    // Period counter and registered bit clock; both collapse to 0 when stopped.
    always_ff @(posedge clock_i) begin
        if (reset_i || !run_i) begin
            r_cnt     <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
            r_pdm_clk <= (r_cnt >= CW'(DIV / 2));
        end
    end

endmodule

// File: rtl/pdm_deserializer.sv
// PDM receiver: samples the mic bit stream, packs MSB-first words, valid/ready out.
// Optional PDM_DESER_POPCOUNT_EN adds ones_o, the count of 1 bits per word.
module pdm_deserializer
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH        = 16,
    parameter int SYSTEM_FREQUENCY   = 100000000,
    parameter int SAMPLING_FREQUENCY = 1000000,
    parameter int WARMUP_WORDS       = 2
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    output logic                   pdm_clk_o,
    output logic                   pdm_lrsel_o,
    input  logic                   pdm_data_i,
    output logic [WORD_LENGTH-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o,
    output logic                   busy_o
`ifdef PDM_DESER_POPCOUNT_EN
    ,
    output logic [$clog2(WORD_LENGTH+1)-1:0] ones_o
`endif
);

    localparam int DIV = pdm_div(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
    localparam int WL  = WORD_LENGTH;
    localparam int BW  = $clog2(WL);
    localparam int WW  = (WARMUP_WORDS > 1) ? $clog2(WARMUP_WORDS) : 1;

    generate
        if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
            $error("pdm_deserializer: clock ratio must be even and >= 4");
        end
        if (WL < 2) begin : g_bad_wl
            $error("pdm_deserializer: WORD_LENGTH must be >= 2");
        end
    endgenerate

    pdm_state_t r_state;
    pdm_state_t w_next;

    logic [PDM_SYNC_STAGES-1:0] r_sync;
    logic [WL-1:0]              r_shift;
    logic [BW-1:0]              r_bit_cnt;
    logic [WW-1:0]              r_warm_cnt;
    logic [WL-1:0]              r_data;
    logic                       r_valid;
    logic                       r_overrun;

    logic          w_run;
    logic          w_busy;
    logic          w_xfer;
    logic          w_strobe;
    logic          w_pdm_clk;
    logic          w_bit;
    logic          w_last_bit;
    logic          w_word_done;
    logic          w_warm_done;
    logic [WL-1:0] w_word;

    assign w_bit       = r_sync[PDM_SYNC_STAGES-1];
    assign w_last_bit  = (r_bit_cnt == BW'(WL - 1));
    assign w_word_done = w_strobe && w_last_bit;
    assign w_word      = {r_shift[WL-2:0], w_bit};
    assign w_warm_done = w_word_done
                      && (r_warm_cnt == WW'(WARMUP_WORDS - 1));

    assign pdm_clk_o   = w_pdm_clk;
    assign pdm_lrsel_o = 1'b0;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign overrun_o   = r_overrun;
    assign busy_o      = w_busy;

    pdm_clock_gen #(
        .DIV(DIV)
    ) u_clock_gen (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .run_i    (w_run),
        .pdm_clk_o(w_pdm_clk),
        .strobe_o (w_strobe)
    );

    // FSM state register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: disable always wins and returns to IDLE.
    always_comb begin
        w_next = r_state;
        if (!enable_i) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    w_next = (WARMUP_WORDS > 0) ? WARMUP : RUN;
                WARMUP:  w_next = w_warm_done ? RUN : WARMUP;
                RUN:     w_next = RUN;
                default: w_next = IDLE;
            endcase
        end
    end

    // FSM outputs: bit clock runs only while active and enabled.
    always_comb begin
        w_busy = (r_state != IDLE);
        w_run  = enable_i && (r_state != IDLE);
        w_xfer = w_word_done && (r_state == RUN);
    end

    // Two-flop synchronizer for the asynchronous mic data.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[PDM_SYNC_STAGES-2:0], pdm_data_i};
        end
    end

    // Shift register, bit counter and warm-up word counter.
    always_ff @(posedge clock_i) begin
        if (reset_i || !enable_i) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_warm_cnt <= '0;
        end else if (w_strobe) begin
            r_shift   <= w_word;
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            if (w_word_done && r_state == WARMUP) begin
                r_warm_cnt <= r_warm_cnt + 1'b1;
            end
        end
    end

    // Output word, valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!enable_i) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            if (r_valid && !ready_i) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

`ifdef PDM_DESER_POPCOUNT_EN
    localparam int OW = $clog2(WL + 1);

    logic [OW-1:0] r_ones;
    logic [OW-1:0] w_pop;

    assign ones_o = r_ones;

    // Population count of the word about to be presented.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WL; i++) begin
            w_pop = w_pop + OW'(w_word[i]);
        end
    end

    // Density value loads alongside data_o.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_ones <= '0;
        end else if (enable_i && w_xfer) begin
            r_ones <= w_pop;
        end
    end
`endif

endmodule

// File: tb/tb_pdm_deserializer.sv
// Self-checking bench for pdm_deserializer (DIV=8, WL=16).
// A second instance with WARMUP_WORDS=2 covers the warm-up drop.
module tb_pdm_deserializer;

    localparam int WL  = 16;
    localparam int DIV = 8;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic en_b = 1'b0;
    logic pdm  = 1'b0;
    logic rdy  = 1'b0;

    logic          pclk_a, lr_a, valid_a, ovr_a, busy_a;
    logic [WL-1:0] data_a;
    logic          pclk_b, lr_b, valid_b, ovr_b, busy_b;
    logic [WL-1:0] data_b;
`ifdef PDM_DESER_POPCOUNT_EN
    logic [$clog2(WL+1)-1:0] ones_a, ones_b;
`endif

    pdm_deserializer #(
        .WORD_LENGTH(WL), .SYSTEM_FREQUENCY(8),
        .SAMPLING_FREQUENCY(1), .WARMUP_WORDS(0)
    ) dut_a (
        .clock_i(clk), .reset_i(rst), .enable_i(en),
        .pdm_clk_o(pclk_a), .pdm_lrsel_o(lr_a), .pdm_data_i(pdm),
        .data_o(data_a), .valid_o(valid_a), .ready_i(rdy),
        .overrun_o(ovr_a), .busy_o(busy_a)
`ifdef PDM_DESER_POPCOUNT_EN
        , .ones_o(ones_a)
`endif
    );

    pdm_deserializer #(
        .WORD_LENGTH(WL), .SYSTEM_FREQUENCY(8),
        .SAMPLING_FREQUENCY(1), .WARMUP_WORDS(2)
    ) dut_b (
        .clock_i(clk), .reset_i(rst), .enable_i(en_b),
        .pdm_clk_o(pclk_b), .pdm_lrsel_o(lr_b), .pdm_data_i(pdm),
        .data_o(data_b), .valid_o(valid_b), .ready_i(rdy),
        .overrun_o(ovr_b), .busy_o(busy_b)
`ifdef PDM_DESER_POPCOUNT_EN
        , .ones_o(ones_b)
`endif
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    bit mon    = 1'b0;

    // Behavioural model: st 0=idle 1=warm-up 2=run, ph = edges since start.
    typedef struct {
        int          st;
        int          ph;
        int          nb;
        int          warm;
        logic [15:0] word;
        logic [15:0] data;
        logic        valid;
        logic        ovr;
        logic        pclk;
        int          ones;
    } m_t;

    m_t mA, mB;

    typedef struct {
        logic [15:0] word;
        logic        rdy;
        logic [15:0] d;
        logic        v;
        logic        o;
        int          ones;
    } vec_t;

    vec_t tbl[5];

    function automatic m_t mstep(input m_t mi, input logic r, input logic e,
                                 input logic b, input logic rd, input int ww);
        m_t          m;
        logic        xf;
        logic [15:0] nw;
        m  = mi;
        xf = 1'b0;
        nw = m.word;
        if (r) begin
            m = '{default: 0};
            return m;
        end
        if (!e) begin
            m.st = 0; m.ph = 0; m.nb = 0; m.warm = 0;
            m.word = '0; m.valid = 1'b0; m.ovr = 1'b0; m.pclk = 1'b0;
            return m;
        end
        if (m.st == 0) begin
            m.st   = (ww > 0) ? 1 : 2;
            m.ph   = 0;
            m.pclk = 1'b0;
            return m;
        end
        m.pclk = ((m.ph % DIV) >= DIV / 2);
        if ((m.ph % DIV) == DIV - 1) begin
            nw     = {m.word[14:0], b};
            m.word = nw;
            m.nb   = m.nb + 1;
            if (m.nb == WL) begin
                m.nb = 0;
                if (m.st == 2) begin
                    xf = 1'b1;
                end else begin
                    m.warm = m.warm + 1;
                    if (m.warm == ww) m.st = 2;
                end
            end
        end
        m.ph = m.ph + 1;
        if (xf) begin
            if (m.valid && !rd) m.ovr = 1'b1;
            m.data  = nw;
            m.valid = 1'b1;
            m.ones  = $countones(nw);
        end else if (m.valid && rd) begin
            m.valid = 1'b0;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mA = mstep(mA, rst, en, pdm, rdy, 0);
        mB = mstep(mB, rst, en_b, pdm, rdy, 2);
        #1;
        if (mon) begin
            chk("mA.data", 32'(data_a), 32'(mA.data));
            chk("mA.valid", 32'(valid_a), 32'(mA.valid));
            chk("mA.ovr", 32'(ovr_a), 32'(mA.ovr));
            chk("mA.busy", 32'(busy_a), 32'(mA.st != 0));
            chk("mA.pclk", 32'(pclk_a), 32'(mA.pclk));
            chk("mA.lrsel", 32'(lr_a), 32'(0));
            chk("mB.data", 32'(data_b), 32'(mB.data));
            chk("mB.valid", 32'(valid_b), 32'(mB.valid));
            chk("mB.ovr", 32'(ovr_b), 32'(mB.ovr));
            chk("mB.busy", 32'(busy_b), 32'(mB.st != 0));
            chk("mB.pclk", 32'(pclk_b), 32'(mB.pclk));
            chk("mB.lrsel", 32'(lr_b), 32'(0));
`ifdef PDM_DESER_POPCOUNT_EN
            chk("mA.ones", 32'(ones_a), 32'(mA.ones));
            chk("mB.ones", 32'(ones_b), 32'(mB.ones));
`endif
        end
    endtask

    // mode 0: ready untouched, 1: random ready, 2: ready=1 on the last edge
    task automatic send_word(input logic [15:0] w, input int mode);
        for (int i = WL - 1; i >= 0; i--) begin
            pdm = w[i];
            for (int c = 0; c < DIV; c++) begin
                if (mode == 1) rdy = ($urandom_range(0, 3) == 0);
                if (mode == 2 && i == 0 && c == DIV - 1) rdy = 1'b1;
                tick();
            end
        end
    endtask

    initial begin
        logic [15:0] rw;
        int          n;

        tbl[0] = '{16'h0F0F, 1'b0, 16'h0F0F, 1'b1, 1'b0, 8};
        tbl[1] = '{16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0};
        tbl[2] = '{16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1};
        tbl[3] = '{16'h7FFE, 1'b1, 16'h7FFE, 1'b1, 1'b1, 14};
        tbl[4] = '{16'h5555, 1'b1, 16'h5555, 1'b1, 1'b1, 8};

        // reset
        rst = 1'b1;
        tick();
        mon = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst.data", 32'(data_a), 32'h0);
        chk("rst.valid", 32'(valid_a), 32'h0);
        chk("rst.ovr", 32'(ovr_a), 32'h0);
        chk("rst.busy", 32'(busy_a), 32'h0);
        chk("rst.pclk", 32'(pclk_a), 32'h0);
        repeat (10) tick();
        chk("idle.pclk", 32'(pclk_a), 32'h0);

        // first word
        en = 1'b1;
        tick();
        chk("en.busy", 32'(busy_a), 32'h1);
        send_word(16'hA5C3, 0);
        chk("w1.data", 32'(data_a), 32'hA5C3);
        chk("w1.valid", 32'(valid_a), 32'h1);
`ifdef PDM_DESER_POPCOUNT_EN
        chk("w1.ones", 32'(ones_a), 32'd8);
`endif

        // overrun
        rdy = 1'b0;
        send_word(16'h1234, 0);
        send_word(16'hFFFF, 0);
        chk("ovr.data", 32'(data_a), 32'hFFFF);
        chk("ovr.flag", 32'(ovr_a), 32'h1);
`ifdef PDM_DESER_POPCOUNT_EN
        chk("ovr.ones", 32'(ones_a), 32'd16);
`endif
        rdy = 1'b1;
        tick();
        chk("cons.valid", 32'(valid_a), 32'h0);
        rdy = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("ovr.sticky", 32'(ovr_a), 32'h1);
        en = 1'b0;
        tick();
        chk("dis.ovr", 32'(ovr_a), 32'h0);
        chk("dis.valid", 32'(valid_a), 32'h0);
        chk("dis.busy", 32'(busy_a), 32'h0);
        chk("dis.hold", 32'(data_a), 32'hFFFF);
        tick();
        chk("dis.pclk", 32'(pclk_a), 32'h0);

        // ready exactly on the transfer edge
        en = 1'b1;
        tick();
        send_word(16'h3C3C, 0);
        chk("rt.first", 32'(data_a), 32'h3C3C);
        send_word(16'hC3A5, 2);
        chk("rt.valid", 32'(valid_a), 32'h1);
        chk("rt.data", 32'(data_a), 32'hC3A5);
        chk("rt.ovr", 32'(ovr_a), 32'h0);
        rdy = 1'b0;

        // partial word discarded by disable
        pdm = 1'b1;
        repeat (7 * DIV + 6) tick();
        chk("part.pclk", 32'(pclk_a), 32'h1);
        en = 1'b0;
        tick();
        chk("part.pclk0", 32'(pclk_a), 32'h0);
        en = 1'b1;
        tick();
        send_word(16'h8001, 0);
        chk("part.data", 32'(data_a), 32'h8001);
        chk("part.valid", 32'(valid_a), 32'h1);
        en = 1'b0;
        tick();

        // warm-up drop on the second instance
        en_b = 1'b1;
        tick();
        chk("wu.busy", 32'(busy_b), 32'h1);
        send_word(16'h1111, 0);
        chk("wu.v1", 32'(valid_b), 32'h0);
        send_word(16'h2222, 0);
        chk("wu.v2", 32'(valid_b), 32'h0);
        chk("wu.d2", 32'(data_b), 32'h0);
        send_word(16'h3333, 0);
        chk("wu.data", 32'(data_b), 32'h3333);
        chk("wu.valid", 32'(valid_b), 32'h1);
        en_b = 1'b0;
        tick();

        // table of back-to-back words with held ready levels
        en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            rdy = tbl[k].rdy;
            send_word(tbl[k].word, 0);
            chk($sformatf("tbl%0d.data", k), 32'(data_a), 32'(tbl[k].d));
            chk($sformatf("tbl%0d.valid", k), 32'(valid_a), 32'(tbl[k].v));
            chk($sformatf("tbl%0d.ovr", k), 32'(ovr_a), 32'(tbl[k].o));
`ifdef PDM_DESER_POPCOUNT_EN
            chk($sformatf("tbl%0d.ones", k), 32'(ones_a), 32'(tbl[k].ones));
`endif
        end
        en = 1'b0;
        tick();

        // random words with random ready, then a random aborted word
        en = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            rw = 16'($urandom);
            send_word(rw, 1);
            chk("rnd.data", 32'(data_a), 32'(rw));
            chk("rnd.valid", 32'(valid_a), 32'h1);
        end
        n = $urandom_range(1, 127);
        for (int k = 0; k < n; k++) begin
            if (k % DIV == 0) pdm = 1'($urandom);
            rdy = 1'($urandom);
            tick();
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        rw = 16'($urandom);
        send_word(rw, 1);
        chk("rnd.after", 32'(data_a), 32'(rw));
        en = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
